imem_arbiter: RTL

Shares the single-port, word-addressed instruction memory between the pipeline fetch stage and the program loader, so a program can be written into memory while the processor is held or running. It sits between the IF stage / loader and the 256-word instruction memory. Requests are granted combinationally and read data returns one cycle later, tagged to the winning requester. An optional starvation guard bounds how long fetch can be locked out.

---
 rtl/imem_arb_pkg.sv | 23 ++
 rtl/imem_arb_starve_ctr.sv | 42 ++++
 rtl/imem_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
// Holds the response-owner encoding, the default memory depth, the NOP
// word returned for out-of-range fetches, and the address range check.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    RSP_NONE   = 2'd0,
    RSP_FETCH  = 2'd1,
    RSP_LOADER = 2'd2
  } rsp_own_e;

  localparam int DEPTH_LOG2_DEF = 8;

  localparam logic [31:0] NOP_WORD = 32'h00000000;

  // True when every byte-address bit above the word index is zero.
  function automatic logic addr_in_range(input logic [31:0] addr, input int depth_log2);
    logic [31:0] hi;
    hi = addr >> (depth_log2 + 2);
    return (hi == 32'd0);
  endfunction

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Starvation guard for the fetch port: counts loader grants taken while
// fetch is waiting and raises trip once BURST_MAX of them have been taken.
// Only instantiated when IMEM_ARB_STARVE_GUARD_EN is defined.
module imem_arb_starve_ctr #(
  parameter int BURST_MAX = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic f_req,
  input  logic l_lock,
  input  logic f_gnt,
  input  logic l_gnt,
  output logic trip
);

  localparam logic [3:0] CNT_MAX = 4'(BURST_MAX);

  logic [3:0] cnt_d;
  logic [3:0] cnt_q;

  // Next count: cleared whenever fetch is idle, served or locked out; else bumps per loader grant.
  always_comb begin
    cnt_d = cnt_q;
    if (l_lock || !f_req || f_gnt) begin
      cnt_d = 4'd0;
    end else if (l_gnt && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign trip = (cnt_q == CNT_MAX) && f_req && !l_lock;

endmodule

// File: rtl/imem_arbiter.sv
// Arbiter sharing the single-port instruction memory between the fetch
// stage and the program loader. Loader has priority; grants are
// combinational and read data returns one cycle later to the owner.
// Optional fetch starvation guard: define IMEM_ARB_STARVE_GUARD_EN.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int BURST_MAX  = 4,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  f_req,
  input  logic [31:0]           f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [31:0]           f_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic                  l_lock,
  input  logic [31:0]           l_addr,
  input  logic [31:0]           l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [31:0]           l_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  logic                  f_in;
  logic                  l_in;
  logic                  trip;
  logic [DEPTH_LOG2-1:0] f_idx;
  logic [DEPTH_LOG2-1:0] l_idx;
  rsp_own_e              rsp_own_d;
  rsp_own_e              rsp_own_q;
  logic                  rsp_oor_d;
  logic                  rsp_oor_q;
  logic                  unused_byte_bits;

  assign f_in  = addr_in_range(f_addr, DEPTH_LOG2);
  assign l_in  = addr_in_range(l_addr, DEPTH_LOG2);
  assign f_idx = f_addr[DEPTH_LOG2+1:2];
  assign l_idx = l_addr[DEPTH_LOG2+1:2];

  // Byte offset within a word has no meaning for a word-wide memory.
  assign unused_byte_bits = ^{f_addr[1:0], l_addr[1:0]};

`ifdef IMEM_ARB_STARVE_GUARD_EN
  imem_arb_starve_ctr #(
    .BURST_MAX(BURST_MAX)
  ) u_starve_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .f_req   (f_req),
    .l_lock  (l_lock),
    .f_gnt   (f_gnt),
    .l_gnt   (l_gnt),
    .trip    (trip)
  );
`else
  localparam int UNUSED_BURST_MAX = BURST_MAX;
  assign trip = 1'b0;
`endif

  // Grant selection: lock keeps fetch out, guard trip hands one cycle to fetch, else loader first.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (reset_n) begin
      if (l_lock) begin
        l_gnt = l_req;
      end else if (trip) begin
        f_gnt = f_req;
      end else if (l_req) begin
        l_gnt = 1'b1;
      end else begin
        f_gnt = f_req;
      end
    end
  end

  // Memory drive and response bookkeeping for the granted requester; out-of-range accesses never reach memory.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    rsp_own_d = RSP_NONE;
    rsp_oor_d = 1'b0;
    if (l_gnt) begin
      mem_en   = l_in;
      mem_we   = l_in && l_we;
      mem_addr = l_in ? l_idx : '0;
      if (l_in && l_we) begin
        mem_wdata = l_wdata;
      end
      if (!l_we) begin
        rsp_own_d = RSP_LOADER;
        rsp_oor_d = !l_in;
      end
    end else if (f_gnt) begin
      mem_en    = f_in;
      mem_addr  = f_in ? f_idx : '0;
      rsp_own_d = RSP_FETCH;
      rsp_oor_d = !f_in;
    end
  end

  // Response owner register; reset drops any read still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_own_q <= RSP_NONE;
      rsp_oor_q <= 1'b0;
    end else begin
      rsp_own_q <= rsp_own_d;
      rsp_oor_q <= rsp_oor_d;
    end
  end

  assign f_rvalid = (rsp_own_q == RSP_FETCH);
  assign l_rvalid = (rsp_own_q == RSP_LOADER);
  assign f_rdata  = (f_rvalid && !rsp_oor_q) ? mem_rdata : NOP_WORD;
  assign l_rdata  = (l_rvalid && !rsp_oor_q) ? mem_rdata : 32'd0;

endmodule
